// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU controller: opcodes, branch conditions,
// FSM states and the PC/operand/ALU select codes driven to the datapath.
package cpu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpSub  = 4'h1,
        OpAnd  = 4'h2,
        OpOr   = 4'h3,
        OpXor  = 4'h4,
        OpNot  = 4'h5,
        OpAddi = 4'h6,
        OpLdw  = 4'h7,
        OpStw  = 4'h8,
        OpBr   = 4'h9,
        OpBl   = 4'hA,
        OpRet  = 4'hB,
        OpHalt = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        CondAlways = 3'b000,
        CondZ      = 3'b001,
        CondNz     = 3'b010,
        CondC      = 3'b011,
        CondN      = 3'b100,
        CondNn     = 3'b101
    } cond_e;

    typedef enum logic [2:0] {
        StFetch,
        StFwait,
        StExec,
        StMem,
        StMwait,
        StWb,
        StHalt
    } state_e;

    localparam logic [2:0] PcSelHold = 3'b000;
    localparam logic [2:0] PcSelInc  = 3'b001;
    localparam logic [2:0] PcSelRel  = 3'b010;
    localparam logic [2:0] PcSelLr   = 3'b011;

    localparam logic [1:0] Op2SelReg = 2'b00;
    localparam logic [1:0] Op2SelImm = 2'b01;

    // One-hot ALU function select {SUB,NOT,NOR,NAND,XOR,OR,AND}; all-zero is ADD.
    localparam logic [6:0] AluAdd = 7'b000_0000;
    localparam logic [6:0] AluAnd = 7'b000_0001;
    localparam logic [6:0] AluOr  = 7'b000_0010;
    localparam logic [6:0] AluXor = 7'b000_0100;
    localparam logic [6:0] AluNot = 7'b010_0000;
    localparam logic [6:0] AluSub = 7'b100_0000;

    // Flags are packed {Z, C, N}.
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] flags);
        logic taken;
        case (cond)
            CondAlways: taken = 1'b1;
            CondZ:      taken = flags[2];
            CondNz:     taken = !flags[2];
            CondC:      taken = flags[1];
            CondN:      taken = flags[0];
            CondNn:     taken = !flags[0];
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/onehot3to8.sv
// 3-to-8 one-hot decoder used for the register-slice select lines.
module onehot3to8 (
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    assign o_onehot = 8'b0000_0001 << i_sel;

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM: fetches an instruction over the system bus, decodes
// it and sequences the datapath strobes, register selects and PC/LR updates.
module control_fsm
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        nReset,
    input  logic [15:0] SysBus,
    input  logic        Z,
    input  logic        C,
    input  logic        N,
    input  logic        nWait,
    output logic        ALE,
    output logic        nOE,
    output logic        nWE,
    output logic [7:0]  Rs1,
    output logic [7:0]  Rs2,
    output logic [7:0]  Rw,
    output logic        Op1Sel,
    output logic [1:0]  Op2Sel,
    output logic        WdSel,
    output logic [2:0]  PcSel,
    output logic        PcWe,
    output logic        PcEn,
    output logic        LrSel,
    output logic        LrWe,
    output logic        LrEn,
    output logic [6:0]  AluSel,
    output logic        CIn,
    output logic [7:0]  Imm,
    output logic        Halted
);

    state_e      r_state, w_state_next;
    logic [15:0] r_ir;
    logic [2:0]  r_flags;
    logic        w_ir_we, w_flags_we;
    opcode_e     w_op;
    logic [7:0]  w_rd_oh, w_ra_oh, w_rb_oh;
    logic [7:0]  w_imm5_sext;
    logic        w_is_store;

    assign w_op        = opcode_e'(r_ir[15:12]);
    assign w_imm5_sext = {{3{r_ir[4]}}, r_ir[4:0]};
    assign w_is_store  = (w_op == OpStw);

    onehot3to8 u_dec_rd (.i_sel(r_ir[11:9]), .o_onehot(w_rd_oh));
    onehot3to8 u_dec_ra (.i_sel(r_ir[8:6]),  .o_onehot(w_ra_oh));
    onehot3to8 u_dec_rb (.i_sel(r_ir[5:3]),  .o_onehot(w_rb_oh));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= StFetch;
            r_ir    <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ir_we)    r_ir    <= SysBus;
            if (w_flags_we) r_flags <= {Z, C, N};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ir_we      = 1'b0;
        w_flags_we   = 1'b0;
        ALE          = 1'b0;
        nOE          = 1'b1;
        nWE          = 1'b1;
        Rs1          = '0;
        Rs2          = '0;
        Rw           = '0;
        Op1Sel       = 1'b0;
        Op2Sel       = Op2SelReg;
        WdSel        = 1'b0;
        PcSel        = PcSelHold;
        PcWe         = 1'b0;
        PcEn         = 1'b0;
        LrSel        = 1'b0;
        LrWe         = 1'b0;
        LrEn         = 1'b0;
        AluSel       = AluAdd;
        CIn          = 1'b0;
        Imm          = '0;
        Halted       = 1'b0;

        // Outputs are gated by the reset pin itself so no strobe leaks while it is held.
        if (nReset) begin
            case (r_state)
                StFetch: begin
                    ALE          = 1'b1;
                    PcEn         = 1'b1;
                    w_state_next = StFwait;
                end
                StFwait: begin
                    nOE  = 1'b0;
                    PcEn = 1'b1;
                    if (nWait) begin
                        w_ir_we      = 1'b1;
                        PcWe         = 1'b1;
                        PcSel        = PcSelInc;
                        w_state_next = StExec;
                    end
                end
                StExec: begin
                    w_state_next = StFetch;
                    case (w_op)
                        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNot, OpAddi: begin
                            Rs1        = w_ra_oh;
                            Rw         = w_rd_oh;
                            w_flags_we = 1'b1;
                            if (w_op == OpAddi) begin
                                Op2Sel = Op2SelImm;
                                Imm    = w_imm5_sext;
                            end else begin
                                Rs2 = w_rb_oh;
                            end
                            case (w_op)
                                OpSub: begin
                                    AluSel = AluSub;
                                    CIn    = 1'b1;
                                end
                                OpAnd:   AluSel = AluAnd;
                                OpOr:    AluSel = AluOr;
                                OpXor:   AluSel = AluXor;
                                OpNot:   AluSel = AluNot;
                                default: AluSel = AluAdd;
                            endcase
                        end
                        OpLdw, OpStw: begin
                            // Ra + imm5 through the ALU onto the bus as the address.
                            Rs1          = w_ra_oh;
                            Op2Sel       = Op2SelImm;
                            Imm          = w_imm5_sext;
                            ALE          = 1'b1;
                            w_state_next = StMem;
                        end
                        OpBr: begin
                            Imm = r_ir[7:0];
                            if (cond_met(r_ir[11:9], r_flags)) begin
                                PcSel = PcSelRel;
                                PcWe  = 1'b1;
                            end
                        end
                        OpBl: begin
                            Imm   = r_ir[7:0];
                            LrSel = 1'b0;
                            LrWe  = 1'b1;
                            PcSel = PcSelRel;
                            PcWe  = 1'b1;
                        end
                        OpRet: begin
                            LrEn  = 1'b1;
                            PcSel = PcSelLr;
                            PcWe  = 1'b1;
                        end
                        OpHalt:  w_state_next = StHalt;
                        default: w_state_next = StFetch;
                    endcase
                end
                StMem, StMwait: begin
                    if (w_is_store) begin
                        nWE = 1'b0;
                        Rs2 = w_rd_oh;
                    end else begin
                        nOE = 1'b0;
                    end
                    if (r_state == StMem) begin
                        w_state_next = StMwait;
                    end else if (nWait) begin
                        w_state_next = w_is_store ? StFetch : StWb;
                    end
                end
                StWb: begin
                    WdSel        = 1'b1;
                    Rw           = w_rd_oh;
                    w_state_next = StFetch;
                end
                StHalt:  Halted = 1'b1;
                default: w_state_next = StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: hand-encoded instructions with expected
// strobe/select values checked cycle by cycle.
module tb_control_fsm;

    logic        Clock, nReset, Z, C, N, nWait;
    logic [15:0] SysBus;
    logic        ALE, nOE, nWE, Op1Sel, WdSel, PcWe, PcEn, LrSel, LrWe, LrEn, CIn, Halted;
    logic [7:0]  Rs1, Rs2, Rw, Imm;
    logic [1:0]  Op2Sel;
    logic [2:0]  PcSel;
    logic [6:0]  AluSel;

    int n_vec;
    int n_err;

    control_fsm dut (
        .Clock(Clock), .nReset(nReset), .SysBus(SysBus), .Z(Z), .C(C), .N(N),
        .nWait(nWait), .ALE(ALE), .nOE(nOE), .nWE(nWE), .Rs1(Rs1), .Rs2(Rs2),
        .Rw(Rw), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel), .WdSel(WdSel), .PcSel(PcSel),
        .PcWe(PcWe), .PcEn(PcEn), .LrSel(LrSel), .LrWe(LrWe), .LrEn(LrEn),
        .AluSel(AluSel), .CIn(CIn), .Imm(Imm), .Halted(Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // From FETCH: present instr with no wait, land in EXEC.
    task automatic do_fetch(input logic [15:0] instr);
        SysBus = instr;
        nWait  = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        SysBus = 16'h0000;
        nWait  = 1'b1;
        {Z, C, N} = 3'b000;
        #2;
        tick();
        tick();
        n_vec++;
        if ({ALE, nOE, nWE, PcWe, LrWe, Halted} !== 6'b011000) begin
            n_err++;
            $display("FAIL reset_strobes: ALE,nOE,nWE,PcWe,LrWe,Halted=%b want 011000",
                     {ALE, nOE, nWE, PcWe, LrWe, Halted});
        end
        n_vec++;
        if ({Rw, Rs1, Rs2, PcSel, AluSel} !== 34'd0) begin
            n_err++;
            $display("FAIL reset_selects: Rw=%h Rs1=%h Rs2=%h PcSel=%b AluSel=%b want all 0",
                     Rw, Rs1, Rs2, PcSel, AluSel);
        end
        nReset = 1'b1;
        #1;
        n_vec++;
        if ({ALE, PcEn} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_release_fetch: ALE,PcEn=%b want 11", {ALE, PcEn});
        end
    endtask

    task automatic test_add();
        SysBus = 16'h0250;
        nWait  = 1'b1;
        tick();
        n_vec++;
        if ({nOE, PcWe, PcSel, PcEn} !== 6'b010011) begin
            n_err++;
            $display("FAIL add_fwait: nOE,PcWe,PcSel,PcEn=%b want 010011",
                     {nOE, PcWe, PcSel, PcEn});
        end
        tick();
        n_vec++;
        if ({Rw, Rs1, Rs2, AluSel, CIn} !== {8'h02, 8'h02, 8'h04, 7'b0, 1'b0}) begin
            n_err++;
            $display("FAIL add_exec: Rw=%h Rs1=%h Rs2=%h AluSel=%b CIn=%b want 02 02 04 0 0",
                     Rw, Rs1, Rs2, AluSel, CIn);
        end
        tick();
        n_vec++;
        if ({ALE, Rw} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL add_next_fetch: ALE=%b Rw=%h want 1 00", ALE, Rw);
        end
    endtask

    task automatic test_sub_branch();
        nWait  = 1'b0;
        SysBus = 16'hFFFF;
        tick();
        tick();
        n_vec++;
        if ({ALE, nOE, PcWe} !== 3'b000) begin
            n_err++;
            $display("FAIL fwait_stall: ALE,nOE,PcWe=%b want 000", {ALE, nOE, PcWe});
        end
        nWait  = 1'b1;
        SysBus = 16'h1250;
        #1;
        n_vec++;
        if ({PcWe, PcSel} !== 4'b1001) begin
            n_err++;
            $display("FAIL fwait_release: PcWe,PcSel=%b want 1001", {PcWe, PcSel});
        end
        {Z, C, N} = 3'b100;
        tick();
        n_vec++;
        if ({AluSel, CIn, Rw} !== {7'b100_0000, 1'b1, 8'h02}) begin
            n_err++;
            $display("FAIL sub_exec: AluSel=%b CIn=%b Rw=%h want 1000000 1 02", AluSel, CIn, Rw);
        end
        tick();
        {Z, C, N} = 3'b000;
        do_fetch(16'h9205);
        n_vec++;
        if ({PcSel, PcWe, Imm, Rw} !== {3'b010, 1'b1, 8'h05, 8'h00}) begin
            n_err++;
            $display("FAIL br_z_taken: PcSel=%b PcWe=%b Imm=%h Rw=%h want 010 1 05 00",
                     PcSel, PcWe, Imm, Rw);
        end
        tick();
        {Z, C, N} = 3'b100;
        do_fetch(16'h9405);
        n_vec++;
        if (PcWe !== 1'b0) begin
            n_err++;
            $display("FAIL br_nz_not_taken: PcWe=%b want 0", PcWe);
        end
        tick();
        {Z, C, N} = 3'b000;
    endtask

    task automatic test_ldw();
        do_fetch(16'h7644);  // LDW R3,[R1+4]
        n_vec++;
        if ({ALE, Rs1, Op2Sel, Imm, Rw} !== {1'b1, 8'h02, 2'b01, 8'h04, 8'h00}) begin
            n_err++;
            $display("FAIL ldw_exec: ALE=%b Rs1=%h Op2Sel=%b Imm=%h Rw=%h want 1 02 01 04 00",
                     ALE, Rs1, Op2Sel, Imm, Rw);
        end
        nWait = 1'b0;
        tick();
        n_vec++;
        if ({nOE, nWE} !== 2'b01) begin
            n_err++;
            $display("FAIL ldw_mem: nOE,nWE=%b want 01", {nOE, nWE});
        end
        tick();
        tick();
        n_vec++;
        if ({nOE, Rw, WdSel} !== {1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL ldw_mwait_stall: nOE=%b Rw=%h WdSel=%b want 0 00 0", nOE, Rw, WdSel);
        end
        tick();
        nWait = 1'b1;
        n_vec++;
        if ({nOE, Rw} !== {1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL ldw_mwait_7: nOE=%b Rw=%h want 0 00", nOE, Rw);
        end
        tick();
        n_vec++;
        if ({Rw, WdSel, nOE} !== {8'h08, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL ldw_wb_cycle8: Rw=%h WdSel=%b nOE=%b want 08 1 1", Rw, WdSel, nOE);
        end
        tick();
        n_vec++;
        if ({ALE, Rw} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL ldw_next_fetch: ALE=%b Rw=%h want 1 00", ALE, Rw);
        end
    endtask

    task automatic test_stw();
        do_fetch(16'h8A48);  // STW R5,[R1+8]
        n_vec++;
        if ({ALE, Imm, Rw} !== {1'b1, 8'h08, 8'h00}) begin
            n_err++;
            $display("FAIL stw_exec: ALE=%b Imm=%h Rw=%h want 1 08 00", ALE, Imm, Rw);
        end
        tick();
        n_vec++;
        if ({nWE, nOE, Rs2, Rw} !== {1'b0, 1'b1, 8'h20, 8'h00}) begin
            n_err++;
            $display("FAIL stw_mem: nWE=%b nOE=%b Rs2=%h Rw=%h want 0 1 20 00", nWE, nOE, Rs2, Rw);
        end
        tick();
        tick();
        n_vec++;
        if ({ALE, nWE, Rw} !== {1'b1, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL stw_done_fetch: ALE=%b nWE=%b Rw=%h want 1 1 00", ALE, nWE, Rw);
        end
    endtask

    task automatic test_bl_ret();
        do_fetch(16'hA010);
        n_vec++;
        if ({LrWe, LrSel, PcWe, PcSel, Imm} !== {1'b1, 1'b0, 1'b1, 3'b010, 8'h10}) begin
            n_err++;
            $display("FAIL bl_exec: LrWe=%b LrSel=%b PcWe=%b PcSel=%b Imm=%h want 1 0 1 010 10",
                     LrWe, LrSel, PcWe, PcSel, Imm);
        end
        tick();
        do_fetch(16'hB000);
        n_vec++;
        if ({PcSel, PcWe, LrWe} !== 5'b01110) begin
            n_err++;
            $display("FAIL ret_exec: PcSel,PcWe,LrWe=%b want 01110", {PcSel, PcWe, LrWe});
        end
        tick();
        do_fetch(16'hC000);
        n_vec++;
        if ({Rw, PcWe, LrWe} !== 10'd0) begin
            n_err++;
            $display("FAIL nop_exec: Rw=%h PcWe=%b LrWe=%b want 00 0 0", Rw, PcWe, LrWe);
        end
        tick();
    endtask

    task automatic test_fwait_reset();
        nWait  = 1'b0;
        SysBus = 16'h0250;
        tick();
        tick();
        nReset = 1'b0;
        #1;
        n_vec++;
        if ({PcWe, nOE, ALE} !== 3'b010) begin
            n_err++;
            $display("FAIL fwait_abort: PcWe,nOE,ALE=%b want 010", {PcWe, nOE, ALE});
        end
        tick();
        nWait  = 1'b1;
        nReset = 1'b1;
        #1;
        n_vec++;
        if ({ALE, PcWe} !== 2'b10) begin
            n_err++;
            $display("FAIL fwait_abort_fetch: ALE,PcWe=%b want 10", {ALE, PcWe});
        end
        {Z, C, N} = 3'b100;
        do_fetch(16'h9205);  // flags were cleared, so BR Z must fall through
        n_vec++;
        if (PcWe !== 1'b0) begin
            n_err++;
            $display("FAIL flags_cleared_br: PcWe=%b want 0", PcWe);
        end
        tick();
        {Z, C, N} = 3'b000;
    endtask

    task automatic test_halt();
        do_fetch(16'hF000);
        n_vec++;
        if (Halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_exec: Halted=%b want 0", Halted);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({Halted, ALE, nOE, nWE, PcWe} !== 5'b10110) begin
                n_err++;
                $display("FAIL halt_hold_%0d: Halted,ALE,nOE,nWE,PcWe=%b want 10110",
                         i, {Halted, ALE, nOE, nWE, PcWe});
            end
        end
        nReset = 1'b0;
        #1;
        n_vec++;
        if (Halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_reset: Halted=%b want 0", Halted);
        end
        tick();
        nReset = 1'b1;
        #1;
        n_vec++;
        if ({ALE, Halted} !== 2'b10) begin
            n_err++;
            $display("FAIL halt_release_fetch: ALE,Halted=%b want 10", {ALE, Halted});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_add();
        test_sub_branch();
        test_ldw();
        test_stw();
        test_bl_ret();
        test_fwait_reset();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
